msrv32_alu_operand_stage: RTL and testbench
===========================================

Name: msrv32_alu_operand_stage

Overview:
Registered operand-issue stage directly upstream of msrv32_alu. It accepts decoded operand packets (op1, op2, 4-bit ALU opcode, rd address) from decode/register-read over a valid/ready handshake and presents them to the combinational ALU. A 2-entry skid buffer gives full throughput with a registered upstream ready. The stage also supports pipeline flush and keeps a saturating back-pressure stall counter.

Parameters:
XLEN, 32, operand width (op1/op2)
OPC_W, 4, ALU opcode width (matches msrv32_alu opcode_in)
RD_W, 5, destination register address width
CNT_W, 16, stall counter width

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n_in  input  1  asynchronous active-low reset
valid_in  input  1  upstream packet valid
ready_out  output  1  stage can accept a packet this cycle (registered)
op1_in  input  XLEN  operand 1
op2_in  input  XLEN  operand 2
opcode_in  input  OPC_W  ALU opcode
rd_addr_in  input  RD_W  destination register
valid_out  output  1  packet presented to ALU is valid
ready_in  input  1  downstream (ALU/writeback) accepts packet
op1_out  output  XLEN  to msrv32_alu op1_in
op2_out  output  XLEN  to msrv32_alu op2_in
opcode_out  output  OPC_W  to msrv32_alu opcode_in
rd_addr_out  output  RD_W  travels alongside ALU result
flush_in  input  1  synchronous flush, discards all held packets
clear_stats_in  input  1  synchronous clear of stall counter
stall_cnt_out  output  CNT_W  cycles with valid_out=1 and ready_in=0
occupancy_out  output  2  packets held (0..2)

Behaviour:
- Reset (rst_n_in=0, async): state EMPTY; valid_out=0, ready_out=1, op1_out/op2_out=0, opcode_out=0, rd_addr_out=0, stall_cnt_out=0, occupancy_out=0. Skid registers cleared.
- Storage: main register (drives *_out) and skid register. push = valid_in & ready_out; pop = valid_out & ready_in.
- valid_out = main full. ready_out = !skid full, registered (no combinational path from ready_in).
- States and transitions:
  - EMPTY (occ 0): push -> ONE, main<=in.
  - ONE (occ 1): push&pop -> ONE, main<=in. push only -> TWO, skid<=in. pop only -> EMPTY. Neither -> hold.
  - TWO (occ 2): ready_out=0, so no push. pop -> ONE, main<=skid. No pop -> hold.
- Strict FIFO order; no packet dropped or duplicated except by flush.
- Outputs stable while valid_out=1 and ready_in=0; upstream may change *_in freely when ready_out=0.
- Latency: a packet pushed into EMPTY appears on *_out the next cycle. Sustained push&pop gives 1 packet/cycle.
- flush_in=1: highest priority. Next cycle EMPTY, valid_out=0, ready_out=1, occupancy 0. A same-cycle push is discarded and a same-cycle pop is still considered consumed. Data registers hold their values (not cleared).
- stall_cnt: +1 each cycle valid_out & !ready_in. Saturates at 2^CNT_W-1 (no wrap). clear_stats_in has priority over increment. Unaffected by flush.
- Payload is passed unmodified; rd_addr=0 is not special-cased.
- Opcode is not checked; undefined opcodes pass through.

Test Plan:
- Reset then push {op1=10, op2=5, opc=0000, rd=3} with ready_in=1 -> next cycle valid_out=1, op1_out=10, op2_out=5, opcode_out=0000; ALU result_out=15; occupancy 1 then 0 after pop.
- Back-pressure: ready_in=0, push {8,3,1000} then {1234,5678,0111} -> occupancy 2, ready_out=0 on the following cycle; release ready_in -> outputs {8,3} then {1234,5678} in order; stall_cnt_out equals the count of stalled cycles.
- Throughput: 100 back-to-back packets (op1=i, op2=2i) with ready_in=1 -> 100 pops in 101 cycles; every op1_out/op2_out pair matches.
- Flush: occupancy 2 plus valid_in=1 and flush_in=1 -> next cycle valid_out=0, ready_out=1, occupancy 0; the incoming packet never appears.
- Counter saturation and clear: CNT_W=4, hold ready_in=0 for 20 cycles -> stall_cnt_out=15 and stays there. clear_stats_in=1 -> 0 next cycle.
- Async reset mid-operation: assert rst_n_in low at occupancy 2, off a clock edge -> outputs reach reset values immediately without waiting for clk_in.

Source files
------------

// File: rtl/msrv32_alu_operand_stage.sv
// Registered operand-issue stage feeding msrv32_alu: a 2-entry skid buffer
// with registered upstream ready, flush, and a saturating stall counter.
module msrv32_alu_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OPC_W = 4,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [XLEN-1:0]  op1_in,
  input  logic [XLEN-1:0]  op2_in,
  input  logic [OPC_W-1:0] opcode_in,
  input  logic [RD_W-1:0]  rd_addr_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  op1_out,
  output logic [XLEN-1:0]  op2_out,
  output logic [OPC_W-1:0] opcode_out,
  output logic [RD_W-1:0]  rd_addr_out,
  input  logic             flush_in,
  input  logic             clear_stats_in,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [1:0]       occupancy_out
);

  localparam int unsigned PW = 2*XLEN + OPC_W + RD_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   main_q, skid_q, pkt_in;
  logic            ready_q;
  logic            push, pop;
  logic            load_main_in, load_main_skid, load_skid;
  logic [CNT_W-1:0] stall_q;

  assign pkt_in    = {op1_in, op2_in, opcode_in, rd_addr_in};
  assign valid_out = (state_q != EMPTY);
  assign ready_out = ready_q;
  assign push      = valid_in & ready_q;
  assign pop       = valid_out & ready_in;

  assign {op1_out, op2_out, opcode_out, rd_addr_out} = main_q;
  assign stall_cnt_out = stall_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins: drop everything, leave data registers untouched.
    if (flush_in) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    occupancy_out = 2'd0;
    unique case (state_q)
      ONE:     occupancy_out = 2'd1;
      TWO:     occupancy_out = 2'd2;
      default: occupancy_out = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      // Ready is the registered image of "skid will be empty next cycle".
      ready_q <= (state_d != TWO);
      if (load_main_in)
        main_q <= pkt_in;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= pkt_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      stall_q <= '0;
    else if (clear_stats_in)
      stall_q <= '0;
    else if (valid_out && !ready_in && stall_q != '1)
      stall_q <= stall_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_msrv32_alu_operand_stage.sv
// Randomised and directed bench for msrv32_alu_operand_stage, checked against
// a queue-based packet model.
module tb_msrv32_alu_operand_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [OPC_W-1:0] opc;
    logic [RD_W-1:0]  rd;
  } pkt_t;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic [XLEN-1:0]  op1_in = '0;
  logic [XLEN-1:0]  op2_in = '0;
  logic [OPC_W-1:0] opcode_in = '0;
  logic [RD_W-1:0]  rd_addr_in = '0;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic [XLEN-1:0]  op1_out;
  logic [XLEN-1:0]  op2_out;
  logic [OPC_W-1:0] opcode_out;
  logic [RD_W-1:0]  rd_addr_out;
  logic             flush_in = 1'b0;
  logic             clear_stats_in = 1'b0;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [1:0]       occupancy_out;

  msrv32_alu_operand_stage #(
    .XLEN (XLEN),
    .OPC_W(OPC_W),
    .RD_W (RD_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .op1_in        (op1_in),
    .op2_in        (op2_in),
    .opcode_in     (opcode_in),
    .rd_addr_in    (rd_addr_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .op1_out       (op1_out),
    .op2_out       (op2_out),
    .opcode_out    (opcode_out),
    .rd_addr_out   (rd_addr_out),
    .flush_in      (flush_in),
    .clear_stats_in(clear_stats_in),
    .stall_cnt_out (stall_cnt_out),
    .occupancy_out (occupancy_out)
  );

  always #5 clk_in = ~clk_in;

  int   n_checks = 0;
  int   n_pass   = 0;
  pkt_t model_q[$];
  int   model_cnt = 0;
  int   dut_pops  = 0;

  always @(posedge clk_in)
    if (valid_out && ready_in) dut_pops <= dut_pops + 1;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_cnt = 0;
  endtask

  // One clock of the reference: what the stage should hold after this edge.
  task automatic model_step(input logic v, input pkt_t p, input logic r,
                            input logic f, input logic c);
    bit has  = (model_q.size() > 0);
    bit push = v && (model_q.size() < 2);
    bit pop  = has && r;
    if (c) model_cnt = 0;
    else if (has && !r && model_cnt < CNT_MAX) model_cnt++;
    if (f) model_q.delete();
    else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(p);
    end
  endtask

  task automatic compare_all();
    check("valid_out", 80'(valid_out), 80'(model_q.size() > 0));
    check("ready_out", 80'(ready_out), 80'(model_q.size() < 2));
    check("occupancy", 80'(occupancy_out), 80'(model_q.size()));
    check("stall_cnt", 80'(stall_cnt_out), 80'(model_cnt));
    if (model_q.size() > 0) begin
      check("op1_out", 80'(op1_out), 80'(model_q[0].op1));
      check("op2_out", 80'(op2_out), 80'(model_q[0].op2));
      check("opcode_out", 80'(opcode_out), 80'(model_q[0].opc));
      check("rd_addr_out", 80'(rd_addr_out), 80'(model_q[0].rd));
    end
  endtask

  // Called at a negedge: drive, take the posedge, then compare at next negedge.
  task automatic drive_cycle(input logic v, input pkt_t p, input logic r,
                             input logic f, input logic c);
    valid_in = v;
    {op1_in, op2_in, opcode_in, rd_addr_in} = p;
    ready_in = r;
    flush_in = f;
    clear_stats_in = c;
    @(posedge clk_in);
    model_step(v, p, r, f, c);
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 80'(valid_out), 80'(0));
    check({tag, "_ready"}, 80'(ready_out), 80'(1));
    check({tag, "_op1"},   80'(op1_out),   80'(0));
    check({tag, "_op2"},   80'(op2_out),   80'(0));
    check({tag, "_opc"},   80'(opcode_out), 80'(0));
    check({tag, "_rd"},    80'(rd_addr_out), 80'(0));
    check({tag, "_cnt"},   80'(stall_cnt_out), 80'(0));
    check({tag, "_occ"},   80'(occupancy_out), 80'(0));
  endtask

  function automatic pkt_t mk(input int unsigned a, input int unsigned b,
                              input int unsigned o, input int unsigned d);
    pkt_t p;
    p.op1 = XLEN'(a);
    p.op2 = XLEN'(b);
    p.opc = OPC_W'(o);
    p.rd  = RD_W'(d);
    return p;
  endfunction

  pkt_t idle;
  int   pops0;

  initial begin
    idle = '0;
    repeat (3) @(negedge clk_in);
    check_reset_values("reset");
    rst_n_in = 1'b1;
    model_reset();
    @(negedge clk_in);

    // Single packet, one-cycle latency, then drained.
    drive_cycle(1, mk(10, 5, 0, 3), 1, 0, 0);
    check("alu_sum", 80'(op1_out + op2_out), 80'(15));
    drive_cycle(0, idle, 1, 0, 0);
    check("drained_occ", 80'(occupancy_out), 80'(0));

    // Back-pressure fills both entries, then drains in order.
    drive_cycle(1, mk(8, 3, 4'b1000, 1), 0, 0, 0);
    drive_cycle(1, mk(1234, 5678, 4'b0111, 2), 0, 0, 0);
    check("bp_full_ready", 80'(ready_out), 80'(0));
    drive_cycle(1, mk(99, 99, 15, 31), 0, 0, 0);
    drive_cycle(0, idle, 1, 0, 0);
    check("bp_second_op1", 80'(op1_out), 80'(1234));
    drive_cycle(0, idle, 1, 0, 0);

    // Throughput: 100 back-to-back packets need 101 cycles.
    pops0 = dut_pops;
    for (int i = 0; i < 100; i++)
      drive_cycle(1, mk(i, 2*i, i % 16, i % 32), 1, 0, 0);
    drive_cycle(0, idle, 1, 0, 0);
    check("throughput_pops", 80'(dut_pops - pops0), 80'(100));

    // Flush with both entries held and a packet arriving.
    drive_cycle(1, mk(1, 1, 1, 1), 0, 0, 0);
    drive_cycle(1, mk(2, 2, 2, 2), 0, 0, 0);
    drive_cycle(1, mk(3, 3, 3, 3), 0, 1, 0);
    check("flush_ready", 80'(ready_out), 80'(1));
    for (int i = 0; i < 3; i++) drive_cycle(0, idle, 1, 0, 0);

    // Stall counter saturation and clear.
    drive_cycle(0, idle, 0, 0, 1);
    drive_cycle(1, mk(7, 7, 7, 7), 0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(0, idle, 0, 0, 0);
    check("cnt_saturated", 80'(stall_cnt_out), 80'(CNT_MAX));
    drive_cycle(0, idle, 0, 0, 1);
    check("cnt_cleared", 80'(stall_cnt_out), 80'(0));
    drive_cycle(0, idle, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++)
      drive_cycle(1'($urandom_range(0, 3) != 0),
                  pkt_t'({$urandom, $urandom, 9'($urandom)}),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 31) == 0));

    // Asynchronous reset while full, away from any clock edge.
    drive_cycle(1, mk(40, 41, 2, 4), 0, 0, 0);
    drive_cycle(1, mk(50, 51, 3, 5), 0, 0, 0);
    check("pre_reset_occ", 80'(occupancy_out), 80'(2));
    valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    @(negedge clk_in);
    compare_all();
    drive_cycle(1, mk(60, 61, 9, 6), 1, 0, 0);
    drive_cycle(0, idle, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
